// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and its helpers.
//   state_e          : sequencer states (idle, memory access, response)
//   DMEM_DEPTH_WORDS : word count of the data memory; must match its storage size
//   ADDR_LSB         : byte-address bits below the word index (word alignment)
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam int unsigned DMEM_DEPTH_WORDS = 32;
  localparam int unsigned ADDR_LSB         = 2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//   r0_* / r1_* : req/we/addr/wdata from each requester; ack/rdata/err back to it
//   mem_*       : addr/wdata/read/write strobes to the memory; rdata back from it
// Modports:
//   slave  : arbiter view (takes requests, drives the memory)
//   master : requester/memory-side view (drives requests and mem_rdata)
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_ack;
  logic [DATA_W-1:0] r0_rdata;
  logic              r0_err;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_ack;
  logic [DATA_W-1:0] r1_rdata;
  logic              r1_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_ack, r0_rdata, r0_err,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_ack, r1_rdata, r1_err,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_ack, r0_rdata, r0_err,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_ack, r1_rdata, r1_err,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant.
//   req0, req1 : requests
//   last_grant : port granted most recently (loses a tie)
//   valid      : some request is present
//   grant      : index of the granted port (meaningful only when valid)
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  always_comb begin
    valid = req0 | req1;
    grant = (req0 && req1) ? ~last_grant : req1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the single-port word-addressed data memory.
// Port 0 is the pipeline MEM stage, port 1 the debug/IO master. Every output is a
// register, so memory strobes are glitch-free and address/data never move while a
// strobe is high.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave modport of dmem_arbiter_if (both requesters plus the memory);
//           its DATA_W/ADDR_W must equal this module's parameters
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic          clk,
  input logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              gnt_valid;
  logic              gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_bad;

  rr_arb2 u_rr_arb2 (
    .req0       (bus.r0_req),
    .req1       (bus.r1_req),
    .last_grant (last_grant_q),
    .valid      (gnt_valid),
    .grant      (gnt)
  );

  always_comb begin
    sel_we    = gnt ? bus.r1_we    : bus.r0_we;
    sel_addr  = gnt ? bus.r1_addr  : bus.r0_addr;
    sel_wdata = gnt ? bus.r1_wdata : bus.r0_wdata;
    addr_bad  = (sel_addr[ADDR_LSB-1:0] != '0) ||
                ((sel_addr >> ADDR_LSB) >= ADDR_W'(DEPTH_WORDS));
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    port_d       = port_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    ack_d        = '0;
    err_d        = '0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          port_d       = gnt;
          last_grant_d = gnt;
          we_d         = sel_we;
          if (addr_bad) begin
            // Rejected: answer straight away, memory is never addressed.
            ack_d[gnt] = 1'b1;
            err_d[gnt] = 1'b1;
            state_d    = StResp;
          end else begin
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_read_d  = ~sel_we;
            mem_write_d = sel_we;
            wait_cnt_d  = CntW'(WAIT_CYCLES - 1);
            state_d     = StAccess;
          end
        end
      end
      StAccess: begin
        if (wait_cnt_q == '0) begin
          mem_read_d     = 1'b0;
          mem_write_d    = 1'b0;
          ack_d[port_q]  = 1'b1;
          if (!we_q) begin
            if (port_q) rdata1_d = bus.mem_rdata;
            else        rdata0_d = bus.mem_rdata;
          end
          state_d = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q - CntW'(1);
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;  // port 0 wins the first tie
      wait_cnt_q   <= '0;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      port_q       <= port_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign bus.r0_ack    = ack_q[0];
  assign bus.r1_ack    = ack_q[1];
  assign bus.r0_err    = err_q[0];
  assign bus.r1_err    = err_q[1];
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a WAIT_CYCLES=1 instance driven by a directed table and
// random transactions against a transaction-level model, plus a WAIT_CYCLES=3
// instance for the wait-state sequence.
module tb_dmem_arbiter;

  localparam int unsigned W1 = 1;
  localparam int unsigned W3 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus3 ();

  dmem_arbiter #(.WAIT_CYCLES(W1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  dmem_arbiter #(.WAIT_CYCLES(W3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // Memories seen by the DUTs: combinational read, write on the clock edge.
  logic [31:0] mem1 [32];
  logic [31:0] mem3 [32];
  bit          mem_init;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) begin
        mem1[i] <= 32'h1000_0000 + 32'(i);
        mem3[i] <= 32'h1000_0000 + 32'(i);
      end
      mem_init <= 1'b1;
    end else begin
      if (bus1.mem_write) mem1[bus1.mem_addr[6:2]] <= bus1.mem_wdata;
      if (bus3.mem_write) mem3[bus3.mem_addr[6:2]] <= bus3.mem_wdata;
    end
  end

  assign bus1.mem_rdata = mem1[bus1.mem_addr[6:2]];
  assign bus3.mem_rdata = mem3[bus3.mem_addr[6:2]];

  // Reference model state.
  logic [31:0] ref_mem [32];
  bit          last_m;
  logic [31:0] held [2];

  int vectors;
  int miscompares;

  typedef struct {
    bit          v0;
    bit          we0;
    logic [31:0] a0;
    logic [31:0] d0;
    bit          v1;
    bit          we1;
    logic [31:0] a1;
    logic [31:0] d1;
    int          first;
    bit          err0;
    bit          err1;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd32);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[6:2]);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'((32 + $urandom_range(0, 15)) << 2);
    if (r == 1) return 32'(($urandom_range(0, 31) << 2) | $urandom_range(1, 3));
    if (r == 2) return $urandom | 32'h8000_0000;
    return 32'($urandom_range(0, 31) << 2);
  endfunction

  // One transaction round on the W=1 instance: both ports optionally request at once,
  // each is held until its ack. Every cycle is checked against the model's timeline.
  task automatic run_txn(input bit v0, input bit we0, input logic [31:0] a0,
                         input logic [31:0] d0, input bit v1, input bit we1,
                         input logic [31:0] a1, input logic [31:0] d1,
                         output int first, output bit e0, output bit e1);
    bit          v [2];
    bit          we [2];
    bit          bad [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [31:0] rv [2];
    int          n_ack [2];
    int          order [2];
    int          cnt, p, last_ack, exp_rd, exp_wr, rd_cnt, wr_cnt;
    bit          ea, stb, prev_stb;
    bit          ack_o [2];
    bit          err_o [2];
    logic [31:0] rd_o [2];
    logic [31:0] prev_a, prev_d;

    v[0] = v0; we[0] = we0; a[0] = a0; d[0] = d0;
    v[1] = v1; we[1] = we1; a[1] = a1; d[1] = d1;
    bad[0] = is_bad(a0);
    bad[1] = is_bad(a1);
    n_ack[0] = 0; n_ack[1] = 0; rv[0] = '0; rv[1] = '0;
    order[0] = 0; order[1] = 1;
    cnt = 0;
    if (v0 && v1) begin
      order[0] = last_m ? 0 : 1;
      order[1] = 1 - order[0];
      cnt = 2;
    end else if (v0) begin
      order[0] = 0; cnt = 1;
    end else if (v1) begin
      order[0] = 1; cnt = 1;
    end

    // Timeline: first grant on the first edge, each later grant two edges after the
    // previous ack (RESP then IDLE); valid accesses take W1 edges to their ack.
    last_ack = 0; exp_rd = 0; exp_wr = 0;
    for (int k = 0; k < cnt; k++) begin
      p = order[k];
      n_ack[p] = ((k == 0) ? 1 : last_ack + 2) + (bad[p] ? 0 : int'(W1));
      if (!bad[p]) begin
        if (we[p]) begin
          ref_mem[widx(a[p])] = d[p];
          exp_wr += int'(W1);
        end else begin
          rv[p] = ref_mem[widx(a[p])];
          exp_rd += int'(W1);
        end
      end
      last_m   = p[0];
      last_ack = n_ack[p];
    end

    bus1.r0_req = v0; bus1.r0_we = we0; bus1.r0_addr = a0; bus1.r0_wdata = d0;
    bus1.r1_req = v1; bus1.r1_we = we1; bus1.r1_addr = a1; bus1.r1_wdata = d1;

    first = 2; e0 = 1'b0; e1 = 1'b0;
    rd_cnt = 0; wr_cnt = 0; prev_stb = 1'b0; prev_a = '0; prev_d = '0;
    for (int n = 1; n <= last_ack + 1; n++) begin
      @(posedge clk);
      #1;
      ack_o[0] = bus1.r0_ack;   ack_o[1] = bus1.r1_ack;
      err_o[0] = bus1.r0_err;   err_o[1] = bus1.r1_err;
      rd_o[0]  = bus1.r0_rdata; rd_o[1]  = bus1.r1_rdata;
      for (int q = 0; q < 2; q++) begin
        ea = v[q] && (n == n_ack[q]);
        if (ea && !bad[q] && !we[q]) held[q] = rv[q];
        chk($sformatf("ack%0d cycle %0d", q, n), 32'(ack_o[q]), 32'(ea));
        chk($sformatf("err%0d cycle %0d", q, n), 32'(err_o[q]), 32'(ea && bad[q]));
        chk($sformatf("rdata%0d cycle %0d", q, n), rd_o[q], held[q]);
        if (ack_o[q]) begin
          if (first == 2) first = q;
          if (q == 0) e0 = err_o[0];
          else        e1 = err_o[1];
        end
      end
      if (ack_o[0]) bus1.r0_req = 1'b0;
      if (ack_o[1]) bus1.r1_req = 1'b0;

      chk("strobe overlap", 32'(bus1.mem_read & bus1.mem_write), 32'd0);
      stb = bus1.mem_read | bus1.mem_write;
      if (stb && prev_stb) begin
        chk("mem_addr stable", bus1.mem_addr, prev_a);
        chk("mem_wdata stable", bus1.mem_wdata, prev_d);
      end
      prev_stb = stb; prev_a = bus1.mem_addr; prev_d = bus1.mem_wdata;
      rd_cnt += int'(bus1.mem_read);
      wr_cnt += int'(bus1.mem_write);
    end
    chk("read strobe cycles", 32'(rd_cnt), 32'(exp_rd));
    chk("write strobe cycles", 32'(wr_cnt), 32'(exp_wr));
    bus1.r0_req = 1'b0;
    bus1.r1_req = 1'b0;
  endtask

  initial begin
    int          first;
    bit          e0, e1;
    bit          rv0, rv1, rwe0, rwe1;
    logic [31:0] ra0, ra1;

    vectors = 0; miscompares = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
    last_m = 1'b1;
    held[0] = '0; held[1] = '0;

    //          v0 we0 a0     d0            v1 we1 a1     d1     first e0 e1 rd0           rd1
    tbl[0]  = '{1, 0, 32'h04, 32'h0,        1, 0, 32'h0C, 32'h0,  0, 0, 0, 32'h1000_0001, 32'h1000_0003};
    tbl[1]  = '{1, 0, 32'h00, 32'h0,        1, 0, 32'h7C, 32'h0,  0, 0, 0, 32'h1000_0000, 32'h1000_001F};
    tbl[2]  = '{1, 1, 32'h08, 32'hDEADBEEF, 0, 0, 32'h00, 32'h0,  0, 0, 0, 32'h1000_0000, 32'h1000_001F};
    tbl[3]  = '{1, 0, 32'h08, 32'h0,        0, 0, 32'h00, 32'h0,  0, 0, 0, 32'hDEADBEEF,  32'h1000_001F};
    tbl[4]  = '{0, 0, 32'h00, 32'h0,        1, 0, 32'h80, 32'h0,  1, 0, 1, 32'hDEADBEEF,  32'h1000_001F};
    tbl[5]  = '{0, 0, 32'h00, 32'h0,        1, 1, 32'h06, 32'h12345678, 1, 0, 1, 32'hDEADBEEF, 32'h1000_001F};
    tbl[6]  = '{0, 0, 32'h00, 32'h0,        1, 1, 32'h10, 32'h11, 1, 0, 0, 32'hDEADBEEF,  32'h1000_001F};
    tbl[7]  = '{0, 0, 32'h00, 32'h0,        1, 1, 32'h14, 32'h22, 1, 0, 0, 32'hDEADBEEF,  32'h1000_001F};
    tbl[8]  = '{1, 0, 32'h10, 32'h0,        0, 0, 32'h00, 32'h0,  0, 0, 0, 32'h11,        32'h1000_001F};
    tbl[9]  = '{0, 0, 32'h00, 32'h0,        1, 0, 32'h14, 32'h0,  1, 0, 0, 32'h11,        32'h22};
    tbl[10] = '{1, 0, 32'h08, 32'h0,        1, 0, 32'h06, 32'h0,  0, 0, 1, 32'hDEADBEEF,  32'h22};
    tbl[11] = '{1, 0, 32'h10, 32'h0,        0, 0, 32'h00, 32'h0,  0, 0, 0, 32'h11,        32'h22};
    tbl[12] = '{1, 0, 32'h00, 32'h0,        1, 0, 32'h08, 32'h0,  1, 0, 0, 32'h1000_0000, 32'hDEADBEEF};
    tbl[13] = '{1, 0, 32'h04, 32'h0,        0, 0, 32'h00, 32'h0,  0, 0, 0, 32'h1000_0001, 32'hDEADBEEF};

    reset = 1'b1;
    bus1.r0_req = 0; bus1.r0_we = 0; bus1.r0_addr = '0; bus1.r0_wdata = '0;
    bus1.r1_req = 0; bus1.r1_we = 0; bus1.r1_addr = '0; bus1.r1_wdata = '0;
    bus3.r0_req = 0; bus3.r0_we = 0; bus3.r0_addr = '0; bus3.r0_wdata = '0;
    bus3.r1_req = 0; bus3.r1_we = 0; bus3.r1_addr = '0; bus3.r1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset acks", {30'd0, bus1.r1_ack, bus1.r0_ack}, 32'd0);
    chk("reset errs", {30'd0, bus1.r1_err, bus1.r0_err}, 32'd0);
    chk("reset strobes", {30'd0, bus1.mem_write, bus1.mem_read}, 32'd0);
    chk("reset mem_addr", bus1.mem_addr, 32'd0);
    chk("reset mem_wdata", bus1.mem_wdata, 32'd0);
    chk("reset r0_rdata", bus1.r0_rdata, 32'd0);
    chk("reset r1_rdata", bus1.r1_rdata, 32'd0);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      run_txn(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
              tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1, first, e0, e1);
      chk($sformatf("tbl%0d first port", i), 32'(first), 32'(tbl[i].first));
      chk($sformatf("tbl%0d err0", i), 32'(e0), 32'(tbl[i].err0));
      chk($sformatf("tbl%0d err1", i), 32'(e1), 32'(tbl[i].err1));
      chk($sformatf("tbl%0d r0_rdata", i), bus1.r0_rdata, tbl[i].rd0);
      chk($sformatf("tbl%0d r1_rdata", i), bus1.r1_rdata, tbl[i].rd1);
    end

    // Wait states on the W=3 instance: read strobe for exactly three cycles, ack after.
    bus3.r0_we = 1'b0; bus3.r0_addr = 32'h0C; bus3.r0_req = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("w3 mem_read cycle %0d", n), 32'(bus3.mem_read), 32'(n <= 3));
      chk($sformatf("w3 mem_write cycle %0d", n), 32'(bus3.mem_write), 32'd0);
      chk($sformatf("w3 r0_ack cycle %0d", n), 32'(bus3.r0_ack), 32'(n == 4));
      if (bus3.mem_read) chk("w3 mem_addr", bus3.mem_addr, 32'h0C);
      if (bus3.r0_ack) begin
        chk("w3 r0_rdata", bus3.r0_rdata, 32'h1000_0003);
        bus3.r0_req = 1'b0;
      end
    end
    bus3.r0_req = 1'b0;

    // Reset in the middle of an access; r1 stays pending through it.
    bus1.r0_we = 1'b0; bus1.r0_addr = 32'h10; bus1.r0_req = 1'b1;
    bus1.r1_we = 1'b0; bus1.r1_addr = 32'h14; bus1.r1_req = 1'b1;
    @(posedge clk);
    #1;
    chk("mid-access strobe", 32'(bus1.mem_read), 32'd1);
    reset = 1'b1;
    #1;
    chk("async reset strobes", {30'd0, bus1.mem_write, bus1.mem_read}, 32'd0);
    chk("async reset acks", {30'd0, bus1.r1_ack, bus1.r0_ack}, 32'd0);
    chk("async reset r0_rdata", bus1.r0_rdata, 32'd0);
    chk("async reset r1_rdata", bus1.r1_rdata, 32'd0);
    chk("async reset mem_addr", bus1.mem_addr, 32'd0);
    bus1.r0_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_m = 1'b1;
    held[0] = '0; held[1] = '0;
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, first, e0, e1);
    chk("post-reset first port", 32'(first), 32'd1);
    chk("post-reset r1_rdata", bus1.r1_rdata, 32'h22);

    // Random transactions against the model.
    for (int it = 0; it < 200; it++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv0 = 1'b1;
      rwe0 = 1'($urandom_range(0, 1));
      rwe1 = 1'($urandom_range(0, 1));
      ra0 = rand_addr();
      ra1 = rand_addr();
      run_txn(rv0, rwe0, ra0, $urandom, rv1, rwe1, ra1, $urandom, first, e0, e1);
    end

    for (int i = 0; i < 32; i++) chk($sformatf("mem word %0d", i), mem1[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port word-addressed data memory. Shares the memory between the pipeline MEM stage (port 0) and a debug/IO master (port 1) using round-robin arbitration and a req/ack handshake. All memory strobes are registered and glitch-free, so the memory's level-sensitive write never sees a changing address or data while the write strobe is high. Out-of-range and misaligned accesses are rejected without touching memory.

## Interface
Parameters:
- `DATA_W`, 32, data width
- `ADDR_W`, 32, byte-address width
- `DEPTH_WORDS`, 32, number of memory words; valid byte addresses are 0 to 4*DEPTH_WORDS-4
- `WAIT_CYCLES`, 1, cycles the memory strobe is held per access; minimum 1

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high
- `r0_req`, `r1_req`  in  1  request; held high until the matching ack
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read
- `r0_addr`, `r1_addr`  in  ADDR_W  byte address
- `r0_wdata`, `r1_wdata`  in  DATA_W  write data
- `r0_ack`, `r1_ack`  out  1  one-cycle completion pulse
- `r0_rdata`, `r1_rdata`  out  DATA_W  read data; valid while ack is high and held until the next ack on that port
- `r0_err`, `r1_err`  out  1  high with ack when the request was rejected
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `mem_rdata`  in  DATA_W  memory read data (combinational from the memory)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - Sample `r0_req` and `r1_req`.
  - Only one request high: grant that port.
  - Both high: grant the port that is not `last_grant`.
  - Neither high: stay in IDLE.
  - On grant:
    - Latch we, addr and wdata into internal registers.
    - Update `last_grant` to the granted port.
    - Check the address: `addr[1:0] != 0` or `addr[ADDR_W-1:2] >= DEPTH_WORDS` is an error.
    - Error: go to RESP with err=1; no memory strobe.
    - Otherwise: load `wait_cnt` with WAIT_CYCLES-1 and go to ACCESS.
- **ACCESS**
  - Drive `mem_addr` and `mem_wdata` from the latched request.
  - Drive `mem_read` = !we and `mem_write` = we.
  - Decrement `wait_cnt` each cycle.
  - When `wait_cnt` is 0: capture `mem_rdata` (reads only), clear both strobes on the same edge, and go to RESP.
- **RESP**
  - Assert ack for the granted port only, with err set as determined in IDLE. Unlatched rdata holds its value.
  - Go to IDLE unconditionally.
  - A req still high in the IDLE that follows is treated as a new request.
- `mem_read` and `mem_write` are never high together and are never high outside ACCESS.
- `mem_addr` and `mem_wdata` are stable throughout every cycle in which a strobe is high.
- A requester dropping req before its ack is a protocol violation. The access completes and the ack is still issued.
- Requests arriving while the FSM is in ACCESS or RESP wait; no request is ever lost.

## Timing
- Reset values:
  - State = IDLE, `last_grant` = 1 (port 0 wins the first tie), `wait_cnt` = 0.
  - All acks, errs and strobes = 0.
  - `mem_addr`, `mem_wdata`, `r0_rdata`, `r1_rdata` = 0.
- Reset asserted mid-access drops the access immediately, with no ack. A write may or may not have landed in memory.
- Valid access: request sampled at edge N.
  - Strobe high for cycles N+1 through N+WAIT_CYCLES.
  - Ack high in cycle N+WAIT_CYCLES+1.
- Error access: ack and err high in cycle N+1.
- Throughput: one access every WAIT_CYCLES+2 cycles.
- Under continuous two-port contention, grants strictly alternate.
- All outputs come from registers; there is no combinational path from input to output.

## Structure
- Shared package `dmem_pkg`:
  - state enum (IDLE/ACCESS/RESP)
  - `DMEM_DEPTH_WORDS` = 32, which must match the data memory's storage size
  - word-alignment constant `ADDR_LSB` = 2
- One sub-module `rr_arb2`: combinational 2-way round-robin grant from (req0, req1, last_grant). It is reusable for the instruction-side arbiter.
- The FSM, counter and latches stay in `dmem_arbiter`.

## Test plan
- **Write then read:** r0 write addr 0x08 data 0xDEADBEEF, then r0 read 0x08 (WAIT_CYCLES=1).
  - Write: `mem_write` high exactly one cycle with addr 0x08.
  - Read: r0_ack two cycles after sampling, r0_rdata = 0xDEADBEEF, err = 0.
- **Simultaneous requests from reset:** r0 read 0x04 and r1 read 0x0C.
  - r0 is served first, then r1 in IDLE immediately after r0's RESP.
  - Repeated simultaneous requests alternate 1, 0, 1...
- **Errors:** r1 read 0x80 (word 32) and r1 write 0x06 (misaligned).
  - Each: r1_ack with r1_err = 1 one cycle after sampling.
  - `mem_read` and `mem_write` stay 0; memory contents unchanged.
- **Wait states:** WAIT_CYCLES=3, r0 read.
  - `mem_read` high exactly 3 cycles with stable `mem_addr`.
  - Ack in cycle N+4; no overlap of strobes.
- **Reset mid-access:** assert reset during ACCESS.
  - Strobes, acks and rdata are 0 asynchronously; FSM in IDLE.
  - After release, a pending r1 req is served normally.
- **Rdata hold:** r0 read returns 0x11, then r1 read returns 0x22.
  - r0_rdata holds 0x11 until r0's next ack.
